// File: rtl/mem_pkg.sv
// Shared types and constants for the M-stage dcache read sequencer.
package mem_pkg;

    localparam int unsigned LINE_LOG2_DEF = 4;
    localparam int unsigned LINE_W_DEF    = 128;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned DATA_W        = 64;
    localparam int unsigned N_ACC         = 4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    typedef logic [1:0] acc_idx_t;

    // Access order: mem1 low line, mem1 high line, mem2 low line, mem2 high line
    localparam acc_idx_t A0 = 2'd0;
    localparam acc_idx_t A1 = 2'd1;
    localparam acc_idx_t A2 = 2'd2;
    localparam acc_idx_t A3 = 2'd3;

    typedef struct packed {
        logic     found;
        acc_idx_t idx;
    } acc_sel_t;

    // Lowest needed access whose index is at or above 'from'
    function automatic acc_sel_t first_needed(input logic [N_ACC-1:0] need, input logic [2:0] from);
        acc_sel_t sel;
        sel.found = 1'b0;
        sel.idx   = A0;
        for (int unsigned i = 0; i < N_ACC; i++) begin
            if (!sel.found && need[i] && (3'(i) >= from)) begin
                sel.found = 1'b1;
                sel.idx   = acc_idx_t'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_rd_seq_if.sv
// Pipeline-side and dcache-side bundles of the M-stage read sequencer.
interface mem_rd_seq_pipe_if;
    logic                        valid_in;
    logic                        flush;
    logic [1:0]                  mem1_rw;
    logic [1:0]                  mem2_rw;
    logic [mem_pkg::ADDR_W-1:0]  mem_addr1;
    logic [mem_pkg::ADDR_W-1:0]  mem_addr1_end;
    logic [mem_pkg::ADDR_W-1:0]  mem_addr2;
    logic [mem_pkg::ADDR_W-1:0]  mem_addr2_end;
    logic                        stall_in;
    logic [mem_pkg::DATA_W-1:0]  mem1_data;
    logic [mem_pkg::DATA_W-1:0]  mem2_data;
    logic                        mem_data_v;
    logic                        stall_out;

    modport master (
        output valid_in, flush, mem1_rw, mem2_rw,
        output mem_addr1, mem_addr1_end, mem_addr2, mem_addr2_end, stall_in,
        input  mem1_data, mem2_data, mem_data_v, stall_out
    );

    modport slave (
        input  valid_in, flush, mem1_rw, mem2_rw,
        input  mem_addr1, mem_addr1_end, mem_addr2, mem_addr2_end, stall_in,
        output mem1_data, mem2_data, mem_data_v, stall_out
    );
endinterface

interface mem_rd_seq_dc_if #(
    parameter int unsigned LINE_W = mem_pkg::LINE_W_DEF
);
    logic                        dc_req_v;
    logic [mem_pkg::ADDR_W-1:0]  dc_req_addr;
    logic                        dc_req_rdy;
    logic                        dc_resp_v;
    logic [LINE_W-1:0]           dc_resp_data;

    modport master (
        output dc_req_v, dc_req_addr,
        input  dc_req_rdy, dc_resp_v, dc_resp_data
    );

    modport slave (
        input  dc_req_v, dc_req_addr,
        output dc_req_rdy, dc_resp_v, dc_resp_data
    );
endinterface

// File: rtl/line_merge.sv
// Extracts a 64-bit operand from a pair of adjacent cache lines at a byte offset.
module line_merge #(
    parameter int unsigned LINE_W = 128,
    parameter int unsigned OFF_W  = 4,
    parameter int unsigned DATA_W = 64
) (
    input  logic [LINE_W-1:0] lo_line_i,
    input  logic [LINE_W-1:0] hi_line_i,
    input  logic [OFF_W-1:0]  offset_i,
    output logic [DATA_W-1:0] data_o
);

    logic [2*LINE_W-1:0] joined;

    assign joined = {hi_line_i, lo_line_i};
    assign data_o = joined[{offset_i, 3'b000} +: DATA_W];

endmodule

// File: rtl/mem_rd_seq.sv
// Issues the mem1/mem2 line reads of an M-stage instruction one at a time and
// merges the returned lines into the two 64-bit operands.
module mem_rd_seq
    import mem_pkg::*;
#(
    parameter int unsigned LINE_LOG2 = LINE_LOG2_DEF,
    parameter int unsigned LINE_W    = LINE_W_DEF
) (
    input  logic             clk,
    input  logic             clr,
    mem_rd_seq_pipe_if.slave pipe,
    mem_rd_seq_dc_if.master  dc
);

    state_t              state_q, state_d;
    acc_idx_t            idx_q, idx_d;
    logic [LINE_W-1:0]   line_q [N_ACC];

    logic                split1, split2;
    logic [N_ACC-1:0]    need;
    acc_sel_t            first_sel, next_sel;
    logic                need_any;
    logic                capture;
    logic                busy;
    logic [ADDR_W-1:0]   acc_addr;
    logic [ADDR_W-1:0]   line_addr;
    logic [DATA_W-1:0]   merge1, merge2;
    logic                unused_ok;

    assign split1 = pipe.mem_addr1[ADDR_W-1:LINE_LOG2] != pipe.mem_addr1_end[ADDR_W-1:LINE_LOG2];
    assign split2 = pipe.mem_addr2[ADDR_W-1:LINE_LOG2] != pipe.mem_addr2_end[ADDR_W-1:LINE_LOG2];

    assign need = {pipe.mem2_rw[0] & split2, pipe.mem2_rw[0],
                   pipe.mem1_rw[0] & split1, pipe.mem1_rw[0]};

    assign first_sel = first_needed(need, 3'd0);
    assign next_sel  = first_needed(need, 3'(idx_q) + 3'd1);
    assign need_any  = first_sel.found;

    // Low accesses use the start address, high accesses the end address
    always_comb begin
        case (idx_q)
            A0:      acc_addr = pipe.mem_addr1;
            A1:      acc_addr = pipe.mem_addr1_end;
            A2:      acc_addr = pipe.mem_addr2;
            default: acc_addr = pipe.mem_addr2_end;
        endcase
    end

    assign line_addr = {acc_addr[ADDR_W-1:LINE_LOG2], {LINE_LOG2{1'b0}}};

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
            idx_q   <= A0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (pipe.valid_in && !pipe.flush && need_any) begin
                    idx_d   = first_sel.idx;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (pipe.flush) begin
                    state_d = dc.dc_req_rdy ? DRAIN : IDLE;
                end else if (dc.dc_req_rdy) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A flush that coincides with the response has nothing left to drain
                if (pipe.flush) begin
                    state_d = dc.dc_resp_v ? IDLE : DRAIN;
                end else if (dc.dc_resp_v) begin
                    if (next_sel.found) begin
                        idx_d   = next_sel.idx;
                        state_d = REQ;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (pipe.flush || !pipe.stall_in) begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (dc.dc_resp_v) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dc.dc_req_v     = 1'b0;
        dc.dc_req_addr  = '0;
        pipe.mem_data_v = 1'b0;
        pipe.stall_out  = 1'b0;
        busy            = 1'b0;
        capture         = 1'b0;
        case (state_q)
            IDLE:  pipe.mem_data_v = pipe.valid_in & ~pipe.flush & ~need_any;
            REQ: begin
                dc.dc_req_v    = 1'b1;
                dc.dc_req_addr = line_addr;
                busy           = 1'b1;
            end
            WAIT: begin
                busy    = 1'b1;
                capture = dc.dc_resp_v & ~pipe.flush;
            end
            DONE:  pipe.mem_data_v = 1'b1;
            DRAIN: busy = 1'b1;
            default: ;
        endcase
        pipe.stall_out = busy | (pipe.valid_in & ~pipe.flush & need_any &
                                 ~((state_q == DONE) & ~pipe.stall_in));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < N_ACC; i++) begin
                line_q[i] <= '0;
            end
        end else if (capture) begin
            line_q[idx_q] <= dc.dc_resp_data;
        end
    end

    line_merge #(.LINE_W(LINE_W), .OFF_W(LINE_LOG2), .DATA_W(DATA_W)) u_merge1 (
        .lo_line_i (line_q[A0]),
        .hi_line_i (split1 ? line_q[A1] : '0),
        .offset_i  (pipe.mem_addr1[LINE_LOG2-1:0]),
        .data_o    (merge1)
    );

    line_merge #(.LINE_W(LINE_W), .OFF_W(LINE_LOG2), .DATA_W(DATA_W)) u_merge2 (
        .lo_line_i (line_q[A2]),
        .hi_line_i (split2 ? line_q[A3] : '0),
        .offset_i  (pipe.mem_addr2[LINE_LOG2-1:0]),
        .data_o    (merge2)
    );

    assign pipe.mem1_data = pipe.mem1_rw[0] ? merge1 : '0;
    assign pipe.mem2_data = pipe.mem2_rw[0] ? merge2 : '0;

    // Write-enable bits and sub-line end offsets carry no information for reads
    assign unused_ok = ^{pipe.mem1_rw[1], pipe.mem2_rw[1],
                         pipe.mem_addr1_end[LINE_LOG2-1:0], pipe.mem_addr2_end[LINE_LOG2-1:0]};

    // The dcache only answers an accepted request
    always_ff @(posedge clk) begin
        if (!clr) begin
            assert (!(dc.dc_resp_v && (state_q == IDLE || state_q == REQ)))
                else $error("dc_resp_v seen while no request is outstanding");
        end
    end

endmodule

// File: tb/tb_mem_rd_seq.sv
// Directed and randomized checks of mem_rd_seq against a byte-level memory model.
module tb_mem_rd_seq;

    logic clk = 1'b0;
    logic clr;

    always #5 clk = ~clk;

    mem_rd_seq_pipe_if pipe ();
    mem_rd_seq_dc_if #(.LINE_W(128)) dc ();

    mem_rd_seq #(.LINE_LOG2(4), .LINE_W(128)) dut (
        .clk  (clk),
        .clr  (clr),
        .pipe (pipe),
        .dc   (dc)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    int          resp_lat = 1;
    bit          rdy_always = 1'b1;
    logic [31:0] req_log [$];

    // Memory contents: bytes 0x1004..0x1007 are AA BB CC DD, the rest a hash of the address
    function automatic logic [7:0] mb(input logic [31:0] a);
        logic [31:0] h;
        if (a[31:2] == 30'h0000_0401) begin
            case (a[1:0])
                2'd0:    return 8'hAA;
                2'd1:    return 8'hBB;
                2'd2:    return 8'hCC;
                default: return 8'hDD;
            endcase
        end
        h = (a ^ 32'h5A5A_1234) * 32'h9E37_79B1;
        return h[23:16] ^ h[31:24];
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] la);
        logic [127:0] l;
        for (int b = 0; b < 16; b++) l[8*b +: 8] = mb(la + 32'(b));
        return l;
    endfunction

    // Byte k of an operand comes from memory if it lies in the start line or the read is split
    function automatic logic [63:0] exp_op(input logic [1:0] rw, input logic [31:0] a, input logic [31:0] e);
        logic [63:0] r;
        logic [31:0] ak;
        r = '0;
        if (rw[0]) begin
            for (int k = 0; k < 8; k++) begin
                ak = a + 32'(k);
                if (ak[31:4] == a[31:4] || a[31:4] != e[31:4]) r[8*k +: 8] = mb(ak);
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Dcache model: one outstanding request, response resp_lat cycles after acceptance
    initial begin
        bit          pending;
        int          remain;
        logic [31:0] paddr;
        bit          hs, rv, c;
        logic [31:0] a;
        pending = 1'b0;
        remain  = 0;
        paddr   = '0;
        dc.dc_req_rdy    = 1'b0;
        dc.dc_resp_v     = 1'b0;
        dc.dc_resp_data  = '0;
        forever begin
            @(negedge clk);
            hs = (dc.dc_req_v === 1'b1) && (dc.dc_req_rdy === 1'b1);
            a  = dc.dc_req_addr;
            rv = dc.dc_resp_v;
            c  = (clr === 1'b1);
            @(posedge clk);
            #1;
            if (c) begin
                pending = 1'b0;
            end else begin
                if (rv) pending = 1'b0;
                if (hs) begin
                    pending = 1'b1;
                    remain  = resp_lat;
                    paddr   = a;
                    req_log.push_back(a);
                end else if (pending) begin
                    remain--;
                end
            end
            dc.dc_req_rdy   = rdy_always ? 1'b1 : 1'($urandom_range(0, 1));
            dc.dc_resp_v    = pending && (remain == 1);
            dc.dc_resp_data = line_of(paddr);
        end
    end

    task automatic set_op(input logic [1:0] rw1, input logic [31:0] a1, input logic [31:0] e1,
                          input logic [1:0] rw2, input logic [31:0] a2, input logic [31:0] e2);
        pipe.mem1_rw       = rw1;
        pipe.mem_addr1     = a1;
        pipe.mem_addr1_end = e1;
        pipe.mem2_rw       = rw2;
        pipe.mem_addr2     = a2;
        pipe.mem_addr2_end = e2;
    endtask

    // Called just after a rising edge; returns at the falling edge where results were checked
    task automatic run_op(input logic [1:0] rw1, input logic [31:0] a1, input logic [31:0] e1,
                          input logic [1:0] rw2, input logic [31:0] a2, input logic [31:0] e2,
                          input int lat, input bit rdy_all, input int hold, input string tag);
        logic [31:0] exp_req [$];
        logic [63:0] x1, x2;
        int          n, nacc;
        bit          got;
        if (rw1[0]) begin
            exp_req.push_back(a1 & ~32'hF);
            if (a1[31:4] != e1[31:4]) exp_req.push_back(e1 & ~32'hF);
        end
        if (rw2[0]) begin
            exp_req.push_back(a2 & ~32'hF);
            if (a2[31:4] != e2[31:4]) exp_req.push_back(e2 & ~32'hF);
        end
        nacc = exp_req.size();
        x1 = exp_op(rw1, a1, e1);
        x2 = exp_op(rw2, a2, e2);
        resp_lat   = lat;
        rdy_always = rdy_all;
        req_log.delete();
        set_op(rw1, a1, e1, rw2, a2, e2);
        pipe.flush    = 1'b0;
        pipe.stall_in = (hold > 0);
        pipe.valid_in = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 400) begin
            @(negedge clk);
            if (pipe.mem_data_v === 1'b1) got = 1'b1;
            else begin
                chk({tag, "/stall_busy"}, 128'(pipe.stall_out), 128'(1));
                n++;
            end
        end
        chk({tag, "/done_seen"}, 128'(got), 128'(1));
        if (rdy_all) chk({tag, "/latency"}, 128'(n), 128'((nacc == 0) ? 0 : 1 + nacc * (1 + lat)));
        chk({tag, "/stall_at_valid"}, 128'(pipe.stall_out), 128'((hold > 0 && nacc > 0) ? 1 : 0));
        chk({tag, "/mem1_data"}, 128'(pipe.mem1_data), 128'(x1));
        chk({tag, "/mem2_data"}, 128'(pipe.mem2_data), 128'(x2));
        chk({tag, "/req_count"}, 128'(req_log.size()), 128'(nacc));
        for (int i = 0; i < nacc; i++) begin
            if (i < req_log.size()) chk({tag, "/req_addr"}, 128'(req_log[i]), 128'(exp_req[i]));
        end
        if (nacc == 0) chk({tag, "/no_req"}, 128'(dc.dc_req_v), 128'(0));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk({tag, "/hold_v"}, 128'(pipe.mem_data_v), 128'(1));
            chk({tag, "/hold_d1"}, 128'(pipe.mem1_data), 128'(x1));
            chk({tag, "/hold_d2"}, 128'(pipe.mem2_data), 128'(x2));
            chk({tag, "/hold_stall"}, 128'(pipe.stall_out), 128'(1));
        end
        if (hold == 0) begin
            @(posedge clk);
            #1;
            pipe.valid_in = 1'b0;
        end
    endtask

    task automatic release_op();
        @(posedge clk);
        #1;
        pipe.stall_in = 1'b0;
        @(posedge clk);
        #1;
        pipe.valid_in = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "/req_v"}, 128'(dc.dc_req_v), 128'(0));
        chk({tag, "/req_addr"}, 128'(dc.dc_req_addr), 128'(0));
        chk({tag, "/data_v"}, 128'(pipe.mem_data_v), 128'(0));
        chk({tag, "/mem1"}, 128'(pipe.mem1_data), 128'(0));
        chk({tag, "/mem2"}, 128'(pipe.mem2_data), 128'(0));
        chk({tag, "/stall"}, 128'(pipe.stall_out), 128'(0));
    endtask

    initial begin
        logic [1:0]  rw1, rw2;
        logic [31:0] a1, a2, e1, e2;
        int          n;

        clr           = 1'b1;
        pipe.valid_in = 1'b0;
        pipe.flush    = 1'b0;
        pipe.stall_in = 1'b0;
        set_op(2'b00, '0, '0, 2'b00, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;

        // Unsplit read of 0x1004..0x1007
        run_op(2'b01, 32'h1004, 32'h1007, 2'b00, 32'h0, 32'h0, 1, 1'b1, 1, "unsplit");
        chk("unsplit/word", 128'(pipe.mem1_data[31:0]), 128'(32'hDDCCBBAA));
        release_op();

        // Read crossing a line boundary
        run_op(2'b01, 32'h100E, 32'h1011, 2'b00, 32'h0, 32'h0, 1, 1'b1, 1, "split");
        chk("split/lo_bytes", 128'(pipe.mem1_data[15:0]), 128'({mb(32'h100F), mb(32'h100E)}));
        chk("split/hi_bytes", 128'(pipe.mem1_data[31:16]), 128'({mb(32'h1011), mb(32'h1010)}));
        release_op();

        run_op(2'b01, 32'h200C, 32'h2013, 2'b01, 32'h300F, 32'h3016, 1, 1'b1, 0, "both_split");
        @(posedge clk);
        #1;

        // Write-only operands need no dcache traffic
        run_op(2'b10, 32'h5000, 32'h5007, 2'b10, 32'h6000, 32'h6007, 1, 1'b1, 0, "no_reads");
        @(negedge clk);
        chk("no_reads/idle_req", 128'(dc.dc_req_v), 128'(0));
        @(posedge clk);
        #1;

        // Flush while the line read is outstanding
        resp_lat   = 5;
        rdy_always = 1'b1;
        req_log.delete();
        set_op(2'b01, 32'h4000, 32'h4007, 2'b00, 32'h0, 32'h0);
        pipe.stall_in = 1'b0;
        pipe.valid_in = 1'b1;
        n = 0;
        while (req_log.size() == 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("flush/req_seen", 128'(req_log.size()), 128'(1));
        pipe.flush = 1'b1;
        @(posedge clk);
        #1;
        pipe.flush    = 1'b0;
        pipe.valid_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush/drain_stall", 128'(pipe.stall_out), 128'(1));
            chk("flush/drain_req", 128'(dc.dc_req_v), 128'(0));
            chk("flush/drain_v", 128'(pipe.mem_data_v), 128'(0));
        end
        @(negedge clk);
        chk("flush/exit_stall", 128'(pipe.stall_out), 128'(0));
        chk("flush/exit_v", 128'(pipe.mem_data_v), 128'(0));
        chk("flush/req_total", 128'(req_log.size()), 128'(1));
        @(posedge clk);
        #1;

        run_op(2'b01, 32'h4108, 32'h410F, 2'b01, 32'h4004, 32'h4005, 1, 1'b1, 0, "after_flush");

        // Downstream stall in DONE, then reset
        run_op(2'b01, 32'h5009, 32'h5010, 2'b01, 32'h6003, 32'h6004, 2, 1'b1, 4, "held");
        @(posedge clk);
        #1;
        clr           = 1'b1;
        pipe.valid_in = 1'b0;
        pipe.stall_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("clr");
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(posedge clk);
        #1;

        for (int t = 0; t < 30; t++) begin
            rw1 = 2'($urandom_range(0, 3));
            rw2 = 2'($urandom_range(0, 3));
            a1  = ($urandom & 32'h000F_FFF0) | 32'($urandom_range(0, 15));
            a2  = ($urandom & 32'h000F_FFF0) | 32'($urandom_range(0, 15));
            e1  = a1 + (32'd1 << $urandom_range(0, 3)) - 32'd1;
            e2  = a2 + (32'd1 << $urandom_range(0, 3)) - 32'd1;
            run_op(rw1, a1, e1, rw2, a2, e2, int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)), 0, "random");
        end

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
